// File: rtl/instr_stream_seq.sv
// Program-level fetch sequencer: issues prog_len accepted reads, drains in-flight returns, pulses done.
// Optional stall timeout: define INSTR_STREAM_SEQ_TIMEOUT_EN.
module instr_stream_seq #(
    parameter int LEN_W                = 16,
    parameter int INSTR_MEM_RD_LATENCY = 1,
    parameter int TIMEOUT_CYC          = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] prog_len,
    input  logic             abort,
    output logic             instr_vld,
    input  logic             instr_mem_rd_rdy,
    input  logic             instr_vld_to_fetcher,
    input  logic             fetcher_rdy,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] issued_cnt,
    output logic [LEN_W-1:0] retired_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [LEN_W-1:0] CNT_MAX = '1;
    localparam logic [LEN_W-1:0] LAT_L   = LEN_W'(INSTR_MEM_RD_LATENCY);

    state_t           r_state, w_state_next;
    logic [LEN_W-1:0] r_len, w_len_next;
    logic [LEN_W-1:0] r_issued, w_issued_next;
    logic [LEN_W-1:0] r_retired, w_retired_next;
    logic             r_err, w_err_next;

    logic             w_idle, w_run, w_drain, w_done_st, w_active;
    logic             w_issue, w_retire, w_final, w_err_now, w_stall_hit;
    logic [LEN_W-1:0] w_issued_upd, w_retired_inc, w_retired_upd;

    assign w_idle    = (r_state == S_IDLE);
    assign w_run     = (r_state == S_RUN);
    assign w_drain   = (r_state == S_DRAIN);
    assign w_done_st = (r_state == S_DONE);
    assign w_active  = w_run || w_drain;

    assign w_issue  = w_run && instr_mem_rd_rdy;
    assign w_retire = w_active && instr_vld_to_fetcher;

    // Counters saturate at all-ones so an error storm never wraps them back to plausible values.
    assign w_issued_upd  = (w_issue && (r_issued != CNT_MAX)) ? r_issued + LEN_W'(1) : r_issued;
    assign w_retired_inc = (r_retired != CNT_MAX) ? r_retired + LEN_W'(1) : r_retired;
    assign w_retired_upd = w_retire ? w_retired_inc : r_retired;
    assign w_final       = w_issue && (r_issued == r_len - LEN_W'(1));

    assign w_err_now = (instr_vld_to_fetcher && (w_idle || w_done_st))
                    || (w_retire && (w_retired_inc > w_issued_upd))
                    || (instr_mem_rd_rdy && !w_run)
                    || (w_active && (w_issued_upd >= w_retired_upd)
                        && ((w_issued_upd - w_retired_upd) > LAT_L));

`ifdef INSTR_STREAM_SEQ_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
    logic [STALL_W-1:0] r_stall;
    logic               w_stall_cond;

    assign w_stall_cond = w_active && fetcher_rdy && !w_issue && !w_retire;
    assign w_stall_hit  = w_stall_cond && (r_stall == STALL_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || !w_stall_cond) begin
            r_stall <= '0;
        end else if (!w_stall_hit) begin
            r_stall <= r_stall + STALL_W'(1);
        end
    end
`else
    logic w_unused;
    assign w_stall_hit = 1'b0;
    assign w_unused    = fetcher_rdy | (TIMEOUT_CYC == 0);
`endif

    always_comb begin
        w_state_next   = r_state;
        w_len_next     = r_len;
        w_issued_next  = r_issued;
        w_retired_next = r_retired;
        w_err_next     = r_err | w_err_now;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_issued_next  = '0;
                    w_retired_next = '0;
                    w_err_next     = w_err_now;
                    if (prog_len != '0) begin
                        w_len_next   = prog_len;
                        w_state_next = S_RUN;
                    end else begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_RUN: begin
                w_issued_next  = w_issued_upd;
                w_retired_next = w_retired_upd;
                if (w_final) begin
                    w_state_next = S_DRAIN;
                end else if (abort) begin
                    // Shrink the program to what has been accepted so DRAIN waits only for those.
                    w_len_next   = w_issued_upd;
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_issued_next  = w_issued_upd;
                w_retired_next = w_retired_upd;
                if (w_retired_upd == r_len) begin
                    w_state_next = S_DONE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (w_stall_hit) begin
            w_state_next   = S_DONE;
            w_issued_next  = r_issued;
            w_retired_next = r_retired;
            w_len_next     = r_len;
            w_err_next     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_len     <= '0;
            r_issued  <= '0;
            r_retired <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_len     <= w_len_next;
            r_issued  <= w_issued_next;
            r_retired <= w_retired_next;
            r_err     <= w_err_next;
        end
    end

    assign instr_vld   = w_run;
    assign busy        = w_active;
    assign done        = w_done_st;
    assign err         = r_err;
    assign issued_cnt  = r_issued;
    assign retired_cnt = r_retired;
endmodule
